// File: rtl/slc3_pkg.sv
// rtl/slc3_pkg.sv - shared state codes, opcodes and mux encodings for the SLC-3 control FSM
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED = 5'd0,
        S_FETCH1 = 5'd1,
        S_FETCH2 = 5'd2,
        S_FETCH3 = 5'd3,
        S_DECODE = 5'd4,
        S_ADD    = 5'd5,
        S_AND    = 5'd6,
        S_NOT    = 5'd7,
        S_BR1    = 5'd8,
        S_BR2    = 5'd9,
        S_JMP    = 5'd10,
        S_JSR1   = 5'd11,
        S_JSR2   = 5'd12,
        S_LDR1   = 5'd13,
        S_LDR2   = 5'd14,
        S_LDR3   = 5'd15,
        S_STR1   = 5'd16,
        S_STR2   = 5'd17,
        S_STR3   = 5'd18,
        S_PAUSE1 = 5'd19,
        S_PAUSE2 = 5'd20
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'd0;
    localparam logic [1:0] PCMUX_ADDER = 2'd1;
    localparam logic [1:0] PCMUX_BUS   = 2'd2;

    localparam logic [1:0] ADDR2_SEXT11 = 2'd0;
    localparam logic [1:0] ADDR2_SEXT9  = 2'd1;
    localparam logic [1:0] ADDR2_SEXT6  = 2'd2;
    localparam logic [1:0] ADDR2_ZERO   = 2'd3;

    localparam logic [1:0] ALUK_ADD   = 2'd0;
    localparam logic [1:0] ALUK_AND   = 2'd1;
    localparam logic [1:0] ALUK_NOT   = 2'd2;
    localparam logic [1:0] ALUK_PASSA = 2'd3;

    // States that hold a memory strobe and share the wait counter
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - 3-bit memory wait counter, done when count equals MEM_WAIT
module mem_wait_counter #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count,
    output logic       done
);

    assign done = (count == 3'(MEM_WAIT));

    // Self-clears on the done cycle so back-to-back accesses start from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 3'd0;
        end else if (clr) begin
            count <= 3'd0;
        end else if (en) begin
            count <= done ? 3'd0 : count + 3'd1;
        end
    end

endmodule

// File: rtl/slc3_control.sv
// rtl/slc3_control.sv - Moore instruction-sequencing FSM driving the SLC-3 datapath
module slc3_control
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        DR,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic        Mem_RD,
    output logic        Mem_WR,
    output logic [4:0]  state_o
);

    state_t     state;
    state_t     state_next;
    logic       mem_active;
    logic       wait_done;
    logic [2:0] wait_count;
    logic       unused_bits;

    assign unused_bits = ^{IR[11:6], IR[4:0], wait_count};
    assign mem_active  = is_mem_state(state);
    assign state_o     = state;

    mem_wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (~mem_active),
        .en    (mem_active),
        .count (wait_count),
        .done  (wait_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_HALTED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_HALTED: if (Run) state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: if (wait_done) state_next = S_FETCH3;
            S_FETCH3: state_next = S_DECODE;
            S_DECODE: begin
                // Unsupported opcodes fall back to fetch as a NOP
                case (IR[15:12])
                    OP_ADD:   state_next = S_ADD;
                    OP_AND:   state_next = S_AND;
                    OP_NOT:   state_next = S_NOT;
                    OP_BR:    state_next = S_BR1;
                    OP_JMP:   state_next = S_JMP;
                    OP_JSR:   state_next = S_JSR1;
                    OP_LDR:   state_next = S_LDR1;
                    OP_STR:   state_next = S_STR1;
                    OP_PAUSE: state_next = S_PAUSE1;
                    default:  state_next = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BR2, S_JMP, S_JSR2, S_LDR3:
                state_next = S_FETCH1;
            S_BR1:    state_next = BEN ? S_BR2 : S_FETCH1;
            S_JSR1:   state_next = S_JSR2;
            S_LDR1:   state_next = S_LDR2;
            S_LDR2:   if (wait_done) state_next = S_LDR3;
            S_STR1:   state_next = S_STR2;
            S_STR2:   state_next = S_STR3;
            S_STR3:   if (wait_done) state_next = S_FETCH1;
            S_PAUSE1: if (Continue) state_next = S_PAUSE2;
            S_PAUSE2: if (!Continue) state_next = S_FETCH1;
            default:  state_next = S_HALTED;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_PC1;
        DR         = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_SEXT11;
        ALUK       = ALUK_ADD;
        MIO_EN     = 1'b0;
        Mem_RD     = 1'b0;
        Mem_WR     = 1'b0;
        unique case (state)
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = PCMUX_PC1;
                LD_PC  = 1'b1;
            end
            S_FETCH2, S_LDR2: begin
                Mem_RD = 1'b1;
                MIO_EN = 1'b1;
                LD_MDR = wait_done;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                SR1MUX  = 1'b1;
                DR      = 1'b1;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR2MUX  = (state == S_NOT) ? 1'b0 : ~IR[5];
                ALUK    = (state == S_ADD) ? ALUK_ADD :
                          (state == S_AND) ? ALUK_AND : ALUK_NOT;
            end
            S_BR2: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = ADDR2_SEXT9;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_JMP: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_JSR1: begin
                GatePC = 1'b1;
                DR     = 1'b0;
                LD_REG = 1'b1;
            end
            S_JSR2: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = ADDR2_SEXT11;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_LDR1, S_STR1: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b0;
                ADDR2MUX   = ADDR2_SEXT6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S_LDR3: begin
                GateMDR = 1'b1;
                DR      = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            // Store data comes from the SR field through the ALU pass path
            S_STR2: begin
                SR1MUX  = 1'b0;
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                MIO_EN  = 1'b0;
                LD_MDR  = 1'b1;
            end
            S_STR3:   Mem_WR = 1'b1;
            S_PAUSE1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slc3_control.sv
// tb/tb_slc3_control.sv - scoreboard bench for slc3_control
module tb_slc3_control;
    import slc3_pkg::*;

    localparam int MW = 2;

    localparam logic [24:0] B_LD_MAR  = 25'd1 << 24;
    localparam logic [24:0] B_LD_MDR  = 25'd1 << 23;
    localparam logic [24:0] B_LD_IR   = 25'd1 << 22;
    localparam logic [24:0] B_LD_BEN  = 25'd1 << 21;
    localparam logic [24:0] B_LD_CC   = 25'd1 << 20;
    localparam logic [24:0] B_LD_REG  = 25'd1 << 19;
    localparam logic [24:0] B_LD_PC   = 25'd1 << 18;
    localparam logic [24:0] B_LD_LED  = 25'd1 << 17;
    localparam logic [24:0] B_GPC     = 25'd1 << 16;
    localparam logic [24:0] B_GMDR    = 25'd1 << 15;
    localparam logic [24:0] B_GALU    = 25'd1 << 14;
    localparam logic [24:0] B_GMARMUX = 25'd1 << 13;
    localparam logic [24:0] B_PC_ADD  = 25'd1 << 11;
    localparam logic [24:0] B_DR      = 25'd1 << 10;
    localparam logic [24:0] B_SR1     = 25'd1 << 9;
    localparam logic [24:0] B_SR2     = 25'd1 << 8;
    localparam logic [24:0] B_A1_PC   = 25'd1 << 7;
    localparam logic [24:0] B_A2_S9   = 25'd1 << 5;
    localparam logic [24:0] B_A2_S6   = 25'd2 << 5;
    localparam logic [24:0] B_A2_ZERO = 25'd3 << 5;
    localparam logic [24:0] B_ALU_AND = 25'd1 << 3;
    localparam logic [24:0] B_ALU_PAS = 25'd3 << 3;
    localparam logic [24:0] B_MIO     = 25'd1 << 2;
    localparam logic [24:0] B_RD      = 25'd1 << 1;
    localparam logic [24:0] B_WR      = 25'd1;

    localparam logic [24:0] V_F1  = B_GPC | B_LD_MAR | B_LD_PC;
    localparam logic [24:0] V_RD  = B_RD | B_MIO;
    localparam logic [24:0] V_F3  = B_GMDR | B_LD_IR;
    localparam logic [24:0] V_MA  = B_SR1 | B_A2_S6 | B_GMARMUX | B_LD_MAR;
    localparam logic [24:0] V_ALU = B_SR1 | B_DR | B_GALU | B_LD_REG | B_LD_CC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Run = 1'b0;
    logic        Continue = 1'b0;
    logic [15:0] IR = 16'h0000;
    logic        BEN = 1'b0;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic DR, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_RD, Mem_WR;
    logic [4:0] state_o;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [29:0] exp_q[$];

    always #5 clk = ~clk;

    slc3_control #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DR(DR), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .MIO_EN(MIO_EN), .Mem_RD(Mem_RD), .Mem_WR(Mem_WR), .state_o(state_o)
    );

    wire [24:0] out_v = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                         GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DR, SR1MUX, SR2MUX,
                         ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_RD, Mem_WR};

    always @(negedge clk) begin
        logic [29:0] e;
        if (mon_en) begin
            checks++;
            if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1 || (Mem_RD && Mem_WR)) begin
                errors++;
                $display("FAIL exclusive: state %0d gates %b rd %b wr %b", state_o,
                         {GatePC, GateMDR, GateALU, GateMARMUX}, Mem_RD, Mem_WR);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (state_o !== e[29:25]) begin
                    errors++;
                    $display("FAIL state: got %0d expected %0d", state_o, e[29:25]);
                end
                checks++;
                if (out_v !== e[24:0]) begin
                    errors++;
                    $display("FAIL outputs in state %0d: got %h expected %h", e[29:25], out_v, e[24:0]);
                end
            end
        end
    end

    task automatic step(input state_t s, input logic [24:0] v);
        exp_q.push_back({5'(s), v});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] ir);
        IR = ir;
        step(S_FETCH1, V_F1);
        repeat (MW) step(S_FETCH2, V_RD);
        step(S_FETCH2, V_RD | B_LD_MDR);
        step(S_FETCH3, V_F3);
        step(S_DECODE, B_LD_BEN);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        step(S_HALTED, 25'd0);
        Run = 1'b1;
        step(S_HALTED, 25'd0);
        Run = 1'b0;

        fetch(16'h1261);
        step(S_ADD, V_ALU);
        fetch(16'h5042);
        step(S_AND, V_ALU | B_SR2 | B_ALU_AND);

        fetch(16'h0402);
        BEN = 1'b0;
        step(S_BR1, 25'd0);
        fetch(16'h0402);
        BEN = 1'b1;
        step(S_BR1, 25'd0);
        step(S_BR2, B_A1_PC | B_A2_S9 | B_PC_ADD | B_LD_PC);
        BEN = 1'b0;

        fetch(16'hC1C0);
        step(S_JMP, B_SR1 | B_A2_ZERO | B_PC_ADD | B_LD_PC);
        fetch(16'h4803);
        step(S_JSR1, B_GPC | B_LD_REG);
        step(S_JSR2, B_A1_PC | B_PC_ADD | B_LD_PC);

        fetch(16'h7240);
        step(S_STR1, V_MA);
        step(S_STR2, B_ALU_PAS | B_GALU | B_LD_MDR);
        repeat (MW + 1) step(S_STR3, B_WR);

        fetch(16'h3000);

        fetch(16'hD00F);
        repeat (2) step(S_PAUSE1, B_LD_LED);
        Continue = 1'b1;
        step(S_PAUSE1, B_LD_LED);
        repeat (2) step(S_PAUSE2, 25'd0);
        Continue = 1'b0;
        step(S_PAUSE2, 25'd0);

        fetch(16'h6242);
        step(S_LDR1, V_MA);
        repeat (MW) step(S_LDR2, V_RD);
        step(S_LDR2, V_RD | B_LD_MDR);
        step(S_LDR3, B_GMDR | B_DR | B_LD_REG | B_LD_CC);

        fetch(16'h6242);
        step(S_LDR1, V_MA);
        step(S_LDR2, V_RD);
        reset = 1'b1;
        #1;
        step(S_HALTED, 25'd0);
        reset = 1'b0;
        step(S_HALTED, 25'd0);
        step(S_HALTED, 25'd0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
